multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 175 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control FSM for a multicycle CPU: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
//   Each non-halt instruction retires exactly once. A retire pulses pc_write,
//   selects the next-PC source and bumps retired_count.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   start                   leaves IDLE
//   reg_write .. halt       decoder controls, sampled in DECODE only
//   branch_taken            ALU compare result, sampled in EXEC only
//   imem_req / imem_ready   instruction fetch handshake
//   dmem_req / dmem_we /
//   dmem_ready              data memory handshake
//   ir_write, alu_en, rf_we, fp_we, wb_sel, pc_write, pc_sel   datapath enables
//   state, halted, fault, retired_count                        status
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        branch,
  input  logic        jump,
  input  logic        mem_to_reg,
  input  logic        is_float,
  input  logic        halt,
  input  logic        branch_taken,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        ir_write,
  output logic        alu_en,
  output logic        rf_we,
  output logic        fp_we,
  output logic        wb_sel,
  output logic        pc_write,
  output logic [1:0]  pc_sel,
  output logic [2:0]  state,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(MEM_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt;
  logic          f_rw, f_mr, f_mw, f_br, f_jp, f_m2r, f_fp;
  logic          taken_q;
  logic          retire;
  logic          taken;

  // In EXEC the live compare result is used; a later retire (branch that
  // also touches memory) falls back to the value captured in EXEC.
  assign taken = (state_q == S_EXEC) ? branch_taken : taken_q;

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    ir_write = 1'b0;
    alu_en   = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    fp_we    = 1'b0;
    wb_sel   = 1'b0;
    retire   = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_cnt == LAST_WAIT) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: state_d = halt ? S_HALT : S_EXEC;
      S_EXEC: begin
        alu_en = 1'b1;
        if (f_mr || f_mw)       state_d = S_MEM;
        else if (f_br)          retire  = 1'b1;
        else if (f_jp && f_rw)  state_d = S_WB;
        else if (f_jp)          retire  = 1'b1;
        else if (f_rw)          state_d = S_WB;
        else                    retire  = 1'b1;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = f_mw;
        if (dmem_ready) begin
          if (f_mr) state_d = S_WB;
          else      retire  = 1'b1;
        end else if (wait_cnt == LAST_WAIT) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        rf_we  = !f_fp;
        fp_we  = f_fp;
        wb_sel = f_m2r;
        retire = 1'b1;
      end
      default: ;  // HALT and FAULT are sticky
    endcase
    if (retire) state_d = S_FETCH;
  end

  always_comb begin
    pc_write = retire;
    pc_sel   = 2'b00;
    if (retire) begin
      if (f_br && taken) pc_sel = 2'b01;
      else if (f_jp)     pc_sel = 2'b10;
    end
  end

  assign state  = state_q;
  assign halted = (state_q == S_HALT);
  assign fault  = (state_q == S_FAULT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wait_cnt      <= '0;
      f_rw          <= 1'b0;
      f_mr          <= 1'b0;
      f_mw          <= 1'b0;
      f_br          <= 1'b0;
      f_jp          <= 1'b0;
      f_m2r         <= 1'b0;
      f_fp          <= 1'b0;
      taken_q       <= 1'b0;
      retired_count <= '0;
    end else begin
      state_q <= state_d;
      // Clears on every state change (covers entry to FETCH and MEM),
      // counts only while a memory request is outstanding.
      if (state_d != state_q)
        wait_cnt <= '0;
      else if (state_q == S_FETCH || state_q == S_MEM)
        wait_cnt <= wait_cnt + 1'b1;
      if (state_q == S_DECODE) begin
        f_rw  <= reg_write;
        f_mr  <= mem_read;
        f_mw  <= mem_write;
        f_br  <= branch;
        f_jp  <= jump;
        f_m2r <= mem_to_reg;
        f_fp  <= is_float;
      end
      if (state_q == S_EXEC) taken_q <= branch_taken;
      if (retire) retired_count <= retired_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst_n, start;
  logic reg_write, mem_read, mem_write, branch, jump, mem_to_reg, is_float, halt;
  logic branch_taken, imem_ready, dmem_ready;
  logic imem_req, dmem_req, dmem_we, ir_write, alu_en, rf_we, fp_we, wb_sel, pc_write;
  logic [1:0]  pc_sel;
  logic [2:0]  state;
  logic        halted, fault;
  logic [31:0] retired_count;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump), .mem_to_reg(mem_to_reg),
    .is_float(is_float), .halt(halt), .branch_taken(branch_taken),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .ir_write(ir_write), .alu_en(alu_en), .rf_we(rf_we), .fp_we(fp_we),
    .wb_sel(wb_sel), .pc_write(pc_write), .pc_sel(pc_sel),
    .state(state), .halted(halted), .fault(fault), .retired_count(retired_count)
  );

  typedef struct {
    string       name;
    logic        rw, mr, mw, br, jp, m2r, fp, tk;
    int          iwait, dwait;
    logic [63:0] trace;   // visited states, one octal digit per cycle
    int          lat;
    logic [1:0]  pcsel;
    logic        e_rf, e_fp, e_wbs;
    int          dreq;
    logic        e_dwe;
  } vec_t;

  vec_t        vecs[$];
  vec_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [7:0] f, input int iw, input int dw,
                              input logic [63:0] tr, input int lat, input logic [1:0] ps,
                              input logic [2:0] wb, input int dreq, input logic dwe);
    vec_t v;
    v.name = nm;
    {v.rw, v.mr, v.mw, v.br, v.jp, v.m2r, v.fp, v.tk} = f;
    v.iwait = iw; v.dwait = dw; v.trace = tr; v.lat = lat; v.pcsel = ps;
    {v.e_rf, v.e_fp, v.e_wbs} = wb;
    v.dreq = dreq; v.e_dwe = dwe;
    return v;
  endfunction

  function automatic logic [63:0] outs();
    return {31'd0, imem_req, dmem_req, dmem_we, ir_write, alu_en, rf_we, fp_we, wb_sel,
            pc_write, pc_sel, state, halted, fault, retired_count[15:0]} | {32'd0, retired_count};
  endfunction

  task automatic clear_inputs();
    start = 0; reg_write = 0; mem_read = 0; mem_write = 0; branch = 0; jump = 0;
    mem_to_reg = 0; is_float = 0; halt = 0; branch_taken = 0; imem_ready = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    model_cnt = 0;
    exp_q.delete();
  endtask

  // Entered and left at posedge+1. Drives one instruction through and
  // compares the retire against the scoreboard entry.
  task automatic run_instr(input vec_t v);
    logic [63:0] trace;
    int lat, fcnt, mcnt, dreq;
    logic rfs, fps, dwe, done;
    vec_t e;
    exp_q.push_back(v);
    start = 1; halt = 0;
    reg_write = v.rw; mem_read = v.mr; mem_write = v.mw; branch = v.br;
    jump = v.jp; mem_to_reg = v.m2r; is_float = v.fp; branch_taken = v.tk;
    trace = 0; lat = 0; fcnt = 0; mcnt = 0; dreq = 0; rfs = 0; fps = 0; dwe = 0; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      imem_ready = (state == 3'd1) && (fcnt == v.iwait);
      dmem_ready = (state == 3'd4) && (mcnt == v.dwait);
      @(negedge clk);
      if (state >= 3'd1 && state <= 3'd5) begin
        trace = {trace[60:0], state};
        lat++;
      end
      if (state == 3'd1) fcnt++;
      if (state == 3'd4) mcnt++;
      if (dmem_req) dreq++;
      rfs |= rf_we; fps |= fp_we; dwe |= dmem_we;
      if (pc_write) begin
        done = 1;
        e = exp_q.pop_front();
        chk({e.name, ".trace"}, trace, e.trace);
        chk({e.name, ".latency"}, 64'(lat), 64'(e.lat));
        chk({e.name, ".pc_sel"}, 64'(pc_sel), 64'(e.pcsel));
        chk({e.name, ".wb_sel"}, 64'(wb_sel), 64'(e.e_wbs));
        chk({e.name, ".rf_we"}, 64'(rfs), 64'(e.e_rf));
        chk({e.name, ".fp_we"}, 64'(fps), 64'(e.e_fp));
        chk({e.name, ".dmem_req_cycles"}, 64'(dreq), 64'(e.dreq));
        chk({e.name, ".dmem_we"}, 64'(dwe), 64'(e.e_dwe));
        chk({e.name, ".retired_before"}, 64'(retired_count), 64'(model_cnt));
        model_cnt = model_cnt + 32'd1;
      end
      @(posedge clk);
      #1;
    end
    imem_ready = 0; dmem_ready = 0;
    if (!done) chk({v.name, ".retire_timeout"}, 64'd0, 64'd1);
  endtask

  // Runs until state reaches `target` or the budget expires; counts
  // cycles with the given request asserted.
  task automatic wait_state(input string nm, input logic [2:0] target, input bit use_dmem,
                            output int req_cycles, output int pw_cycles);
    bit hit;
    req_cycles = 0; pw_cycles = 0; hit = 0;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge clk);
      if (state == target) hit = 1;
      else begin
        if (use_dmem ? dmem_req : imem_req) req_cycles++;
        if (pc_write) pw_cycles++;
        @(posedge clk);
        #1;
      end
    end
    if (!hit) chk({nm, ".reach_state"}, 64'(state), 64'(target));
    else begin @(posedge clk); #1; end
  endtask

  initial begin
    int rq, pw;
    vec_t jv;
    rst_n = 0;
    clear_inputs();
    //         name     rw mr mw br jp m2r fp tk  iw dw  trace                      lat pc  rf,fp,wbs dreq dwe
    vecs.push_back(mk("add",   8'b1000_0000, 0, 0, 64'o1235,                4, 2'b00, 3'b100, 0, 0));
    vecs.push_back(mk("lw",    8'b1100_0100, 0, 3, 64'o12344445,            8, 2'b00, 3'b101, 4, 0));
    vecs.push_back(mk("sw",    8'b0010_0000, 0, 0, 64'o1234,                4, 2'b00, 3'b000, 1, 1));
    vecs.push_back(mk("beq",   8'b0001_0001, 0, 0, 64'o123,                 3, 2'b01, 3'b000, 0, 0));
    vecs.push_back(mk("bne",   8'b0001_0000, 0, 0, 64'o123,                 3, 2'b00, 3'b000, 0, 0));
    vecs.push_back(mk("jal",   8'b1000_1000, 0, 0, 64'o1235,                4, 2'b10, 3'b100, 0, 0));
    vecs.push_back(mk("add_s", 8'b1000_0010, 0, 0, 64'o1235,                4, 2'b00, 3'b010, 0, 0));
    vecs.push_back(mk("j",     8'b0000_1000, 0, 0, 64'o123,                 3, 2'b10, 3'b000, 0, 0));
    vecs.push_back(mk("lw0",   8'b1100_0100, 0, 0, 64'o12345,               5, 2'b00, 3'b101, 1, 0));
    vecs.push_back(mk("add_iw",8'b1000_0000, 2, 0, 64'o111235,              6, 2'b00, 3'b100, 0, 0));
    vecs.push_back(mk("sw_15", 8'b0010_0000, 0, 15, 64'o123_4444_4444_4444_4444, 19, 2'b00, 3'b000, 16, 1));
    vecs.push_back(mk("flw",   8'b1100_0110, 0, 1, 64'o123445,              6, 2'b00, 3'b011, 2, 0));
    vecs.push_back(mk("nop_15",8'b0000_0000, 15, 0, 64'o1111_1111_1111_1111_23, 18, 2'b00, 3'b000, 0, 0));

    // reset state and start requirement
    do_reset();
    chk("reset.outputs", outs(), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("no_start.imem_req", 64'(imem_req), 64'd0);
    chk("no_start.state", 64'(state), 64'd0);

    // instruction table
    foreach (vecs[i]) run_instr(vecs[i]);
    chk("table.retired_count", 64'(retired_count), 64'(model_cnt));

    // fetch timeout: 16 request cycles, then sticky FAULT ignoring start
    do_reset();
    start = 1;
    wait_state("ifetch_to", 3'd7, 1'b0, rq, pw);
    chk("ifetch_to.req_cycles", 64'(rq), 64'd16);
    chk("ifetch_to.fault", 64'(fault), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("ifetch_to.sticky", 64'({state, fault}), 64'({3'd7, 1'b1}));
    do_reset();
    chk("ifetch_to.reset_state", 64'(state), 64'd0);

    // data memory timeout
    start = 1; mem_write = 1; imem_ready = 1;
    wait_state("dmem_to", 3'd7, 1'b1, rq, pw);
    chk("dmem_to.req_cycles", 64'(rq), 64'd16);
    chk("dmem_to.no_retire", 64'(pw), 64'd0);

    // halt: no retire, sticky
    do_reset();
    start = 1; halt = 1; imem_ready = 1;
    wait_state("halt", 3'd6, 1'b0, rq, pw);
    chk("halt.halted", 64'(halted), 64'd1);
    chk("halt.pc_write", 64'(pw), 64'd0);
    chk("halt.retired", 64'(retired_count), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("halt.sticky", 64'({state, halted}), 64'({3'd6, 1'b1}));

    // reset in the middle of a MEM wait
    do_reset();
    start = 1; mem_read = 1; reg_write = 1; mem_to_reg = 1; imem_ready = 1;
    wait_state("mid_mem", 3'd4, 1'b1, rq, pw);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_mem.in_mem", 64'(dmem_req), 64'd1);
    rst_n = 0;
    @(posedge clk);
    #1;
    chk("mid_mem.reset_outputs", outs(), 64'd0);
    do_reset();
    chk("mid_mem.idle", 64'(state), 64'd0);

    // counter wrap
    force dut.retired_count = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.retired_count;
    chk("wrap.preload", 64'(retired_count), 64'hFFFF_FFFF);
    model_cnt = 32'hFFFF_FFFF;
    jv = vecs[7];
    run_instr(jv);
    chk("wrap.count", 64'(retired_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
